// File: rtl/nios_system_pio_ext.sv
// Avalon-MM parallel I/O block: output register with set/clear/blink, synchronised inputs
// with rising-edge capture, and a maskable level interrupt.
module nios_system_pio_ext #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] out_r;
  logic [DATA_WIDTH-1:0] mask_r;
  logic [DATA_WIDTH-1:0] edge_r;
  logic [DATA_WIDTH-1:0] blink_en_r;
  logic [DATA_WIDTH-1:0] sync1_r;
  logic [DATA_WIDTH-1:0] sync2_r;
  logic [DATA_WIDTH-1:0] dly_r;
  logic [DIV_WIDTH-1:0]  div_r;
  logic [DIV_WIDTH-1:0]  cnt_r;
  logic                  irq_r;

  logic                  wr_s;
  logic                  tick_s;
  logic [DATA_WIDTH-1:0] wd_s;
  logic [DATA_WIDTH-1:0] rise_s;
  logic [DATA_WIDTH-1:0] edge_clr_s;
  logic [DATA_WIDTH-1:0] edge_nxt_s;
  logic [DATA_WIDTH-1:0] out_nxt_s;
  logic [DIV_WIDTH-1:0]  cnt_nxt_s;
  logic [31:0]           rd_s;

  assign wd_s = writedata[DATA_WIDTH-1:0];

  // Next-state logic for edge capture, output register and blink counter.
  always_comb begin
    wr_s   = chipselect & ~write_n;
    rise_s = sync2_r & ~dly_r;
    tick_s = (div_r != '0) && (cnt_r == '0);

    if (wr_s && (address == 3'd3)) begin
      edge_clr_s = wd_s;
    end else begin
      edge_clr_s = '0;
    end
    // A new edge outranks a simultaneous write-1-to-clear.
    edge_nxt_s = (edge_r & ~edge_clr_s) | rise_s;

    // CPU writes to the output register swallow a coincident blink tick.
    if (wr_s && (address == 3'd0)) begin
      out_nxt_s = wd_s;
    end else if (wr_s && (address == 3'd4)) begin
      out_nxt_s = out_r | wd_s;
    end else if (wr_s && (address == 3'd5)) begin
      out_nxt_s = out_r & ~wd_s;
    end else if (tick_s) begin
      out_nxt_s = out_r ^ blink_en_r;
    end else begin
      out_nxt_s = out_r;
    end

    if (wr_s && (address == 3'd7)) begin
      cnt_nxt_s = writedata[DIV_WIDTH-1:0];
    end else if (div_r == '0) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == '0) begin
      cnt_nxt_s = div_r;
    end else begin
      cnt_nxt_s = cnt_r - DIV_WIDTH'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_r      <= RESET_VALUE;
      mask_r     <= '0;
      edge_r     <= '0;
      blink_en_r <= '0;
      div_r      <= '0;
      cnt_r      <= '0;
      sync1_r    <= '0;
      sync2_r    <= '0;
      dly_r      <= '0;
      irq_r      <= 1'b0;
    end else begin
      out_r   <= out_nxt_s;
      edge_r  <= edge_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sync1_r <= in_port;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
      irq_r   <= |(edge_r & mask_r);
      if (wr_s && (address == 3'd2)) begin
        mask_r <= wd_s;
      end else begin
        mask_r <= mask_r;
      end
      if (wr_s && (address == 3'd6)) begin
        blink_en_r <= wd_s;
      end else begin
        blink_en_r <= blink_en_r;
      end
      if (wr_s && (address == 3'd7)) begin
        div_r <= writedata[DIV_WIDTH-1:0];
      end else begin
        div_r <= div_r;
      end
    end
  end

  // Zero-wait-state read mux; write-only and unused addresses read zero.
  always_comb begin
    case (address)
      3'd0:    rd_s = 32'(out_r);
      3'd1:    rd_s = 32'(sync2_r);
      3'd2:    rd_s = 32'(mask_r);
      3'd3:    rd_s = 32'(edge_r);
      3'd6:    rd_s = 32'(blink_en_r);
      3'd7:    rd_s = 32'(div_r);
      default: rd_s = 32'd0;
    endcase
  end

  assign readdata = rd_s;
  assign out_port = out_r;
  assign irq      = irq_r;

endmodule

// File: doc/nios_system_pio_ext.md
NIOS_SYSTEM_PIO_EXT -- requirements
Module: nios_system_pio_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: width of out_port, in_port and every per-bit register (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0: reset value of the output data register (DATA_WIDTH bits).
REQ-003 SHALL have parameter DIV_WIDTH, default 24: width of the blink divider and counter (1..32).
REQ-004 SHALL have ports: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have ports: reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 SHALL have ports: address  input  3  Avalon-MM word address.
REQ-007 SHALL have ports: chipselect  input  1  slave select; write_n  input  1  active-low write strobe; writedata  input  32  write data.
REQ-008 SHALL have ports: readdata  output  32  read data; in_port  input  DATA_WIDTH  asynchronous external inputs.
REQ-009 SHALL have ports: out_port  output  DATA_WIDTH  output data register; irq  output  1  registered level interrupt.

Function
REQ-010 A write SHALL occur on a cycle with chipselect=1 and write_n=0; only writedata[DATA_WIDTH-1:0] is used, except at address 7.
REQ-011 Register map SHALL be: 0 OUT (R/W), 1 IN (R), 2 IRQ_MASK (R/W), 3 EDGE_CAP (R, write-1-to-clear), 4 OUTSET (W), 5 OUTCLR (W), 6 BLINK_EN (R/W), 7 BLINK_DIV (R/W, DIV_WIDTH bits).
REQ-012 readdata SHALL be combinational from address, zero-extended to 32 bits, zero-wait-state; addresses 4 and 5 read 0.
REQ-013 out_port SHALL equal the OUT register directly, with no extra pipeline stage.
REQ-014 in_port SHALL pass through a 2-flop synchroniser; IN reads the second stage; a change on in_port is visible in IN 2 cycles later.
REQ-015 A rising edge SHALL be detected when synchroniser stage 2 is 1 and a third delay flop is 0; the detected bit sets in EDGE_CAP on the next clock edge.
REQ-016 Writing 1 to an EDGE_CAP bit SHALL clear it; if set and clear coincide on the same bit, set wins.
REQ-017 A write to OUTSET SHALL OR writedata into OUT; a write to OUTCLR SHALL AND OUT with ~writedata.
REQ-018 The blink counter SHALL load BLINK_DIV on reset and on any BLINK_DIV write; otherwise it decrements by 1 per cycle, and on reaching 0 it asserts tick for one cycle and reloads BLINK_DIV.
REQ-019 BLINK_DIV = 0 SHALL suppress tick permanently, with the counter held at 0.
REQ-020 On tick, OUT bits with BLINK_EN=1 SHALL invert; bits with BLINK_EN=0 SHALL hold.
REQ-021 Simultaneous CPU write to OUT, OUTSET or OUTCLR and tick SHALL apply the CPU write only; the tick is lost for that cycle.
REQ-022 irq SHALL be registered as |(EDGE_CAP & IRQ_MASK), i.e. asserted one cycle after EDGE_CAP/IRQ_MASK make the term true, and deasserted one cycle after it becomes false.

Reset
REQ-023 When reset_n=0 at a clk rising edge: OUT=RESET_VALUE, IRQ_MASK=0, EDGE_CAP=0, BLINK_EN=0, BLINK_DIV=0, counter=0, synchroniser and delay flops=0, irq=0.
REQ-024 Reset SHALL override any simultaneous write or tick; a blink sequence interrupted by reset does not resume.
REQ-025 readdata SHALL reflect reset values in the first cycle after reset is released.

Verification
REQ-026 Reset then write OUT=0x2A5, read address 0 -> 0x000002A5, out_port=0x2A5; OUTSET 0x00A -> 0x2AF; OUTCLR 0x200 -> 0x0AF.
REQ-027 in_port bit3 0->1 with IRQ_MASK=0x008 -> IN bit3 set after 2 cycles, EDGE_CAP=0x008 one cycle later, irq=1 the following cycle; writing 0x008 to address 3 -> irq=0 one cycle after the clear.
REQ-028 Edge on bit0 arriving in the same cycle as a W1C of bit0 -> EDGE_CAP bit0 remains 1.
REQ-029 BLINK_DIV=3, BLINK_EN=0x001, OUT=0 -> out_port bit0 toggles every 4 cycles; set BLINK_DIV=0 -> toggling stops and OUT holds.
REQ-030 OUT write coincident with tick -> OUT equals the written value with no inversion; reset_n=0 mid-blink -> OUT=RESET_VALUE and no further toggles.
